// File: rtl/bp_sweep_ctrl.sv
// Band-pass sweep sequencer: steps the NCO over npts frequencies, averages |ADC| per point.
// Results stall in OUT until res_ready; adc_req holds until adc_ack; abort drops both next edge.
module bp_sweep_ctrl #(
  parameter int FW_W     = 32,
  parameter int ADC_W    = 12,
  parameter int SETTLE   = 1024,
  parameter int AVG_LOG2 = 3,
  parameter int NPTS_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [FW_W-1:0]   cfg_start,
  input  logic [FW_W-1:0]   cfg_step,
  input  logic [NPTS_W-1:0] cfg_npts,
  output logic              busy,
  output logic [FW_W-1:0]   freq_word,
  output logic              freq_load,
  output logic              adc_req,
  input  logic              adc_ack,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [NPTS_W-1:0] res_idx,
  output logic [ADC_W-1:0]  res_mag,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_REQ, S_ACC, S_OUT, S_FIN
  } state_t;

  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [ADC_W-1:0] MAG_MAX = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic [ADC_W-1:0] ADC_MIN = {1'b1, {(ADC_W-1){1'b0}}};

  state_t            state;
  logic [FW_W-1:0]   step_q;
  logic [NPTS_W-1:0] npts_q;
  logic [NPTS_W-1:0] idx;
  logic [SC_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]  smp_cnt;
  logic [ADC_W-1:0]  sample;
  logic [ACC_W-1:0]  acc;
  logic [ADC_W-1:0]  abs_data;
  logic [ACC_W-1:0]  acc_sum;

  // Most negative code has no positive twin; clamp it to full scale.
  always_comb begin
    abs_data = adc_data;
    if (adc_data == ADC_MIN)
      abs_data = MAG_MAX;
    else if (adc_data[ADC_W-1])
      abs_data = -adc_data;
    acc_sum = acc + ACC_W'(sample);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step_q     <= '0;
      npts_q     <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      sample     <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      freq_word  <= '0;
      freq_load  <= 1'b0;
      adc_req    <= 1'b0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_mag    <= '0;
      done       <= 1'b0;
    end else if (abort && state != S_IDLE && state != S_FIN) begin
      state     <= S_FIN;
      freq_load <= 1'b0;
      adc_req   <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            step_q <= cfg_step;
            npts_q <= cfg_npts;
            idx    <= '0;
            if (cfg_npts != '0) begin
              freq_word <= cfg_start;
              freq_load <= 1'b1;
              state     <= S_LOAD;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_LOAD: begin
          freq_load  <= 1'b0;
          settle_cnt <= SC_W'(SETTLE - 1);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            acc     <= '0;
            smp_cnt <= '0;
            adc_req <= 1'b1;
            state   <= S_REQ;
          end else begin
            settle_cnt <= settle_cnt - SC_W'(1);
          end
        end
        S_REQ: begin
          if (adc_ack) begin
            adc_req <= 1'b0;
            sample  <= abs_data;
            state   <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= acc_sum;
          if (smp_cnt == CNT_MAX) begin
            res_valid <= 1'b1;
            res_idx   <= idx;
            res_mag   <= acc_sum[ACC_W-1:AVG_LOG2];
            state     <= S_OUT;
          end else begin
            smp_cnt <= smp_cnt + CNT_W'(1);
            adc_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (idx == npts_q - NPTS_W'(1)) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx       <= idx + NPTS_W'(1);
              freq_word <= freq_word + step_q;
              freq_load <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
